// File: rtl/asrm_uart_tx_if.sv
// Bus-side port bundle for asrm_uart_tx: CPU address/write data/strobe in, read data back.
interface asrm_uart_tx_if #(
    parameter int unsigned wordsize = 16
);
    logic [wordsize-1:0] addr;
    logic [wordsize-1:0] data_in;
    logic                write_en;
    logic [wordsize-1:0] data_out;

    modport master (output addr, output data_in, output write_en, input data_out);
    modport slave  (input addr, input data_in, input write_en, output data_out);
endinterface

// File: rtl/asrm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the asrm bus (data reg at base_addr, status at +1).
// Define ASRM_UART_TX_FIFO_EN for a fifo_depth-entry queue; otherwise a single holding register.
module asrm_uart_tx #(
    parameter int unsigned wordsize   = 16,
    parameter int unsigned base_addr  = 16'hFF00,
    parameter int unsigned clk_div    = 868,
    parameter int unsigned fifo_depth = 4
) (
    input  logic          clk,
    input  logic          reset,
    asrm_uart_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);
    localparam int unsigned BAUD_W = $clog2(clk_div);
    localparam logic [BAUD_W-1:0]   BAUD_LOAD = BAUD_W'(clk_div - 1);
    localparam logic [wordsize-1:0] DATA_ADDR = wordsize'(base_addr);
    localparam logic [wordsize-1:0] STAT_ADDR = wordsize'(base_addr + 1);

    if (wordsize < 8) begin : g_bad_wordsize
        $error("asrm_uart_tx: wordsize must be >= 8");
    end
    if (clk_div < 2) begin : g_bad_clk_div
        $error("asrm_uart_tx: clk_div must be >= 2");
    end
    if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
        $error("asrm_uart_tx: fifo_depth must be a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_d;
    logic              pop_c;
    logic              wr_hit_c, stat_hit_c, push_c;
    logic              q_empty_c, q_full_c;
    logic [7:0]        q_head_c;
    logic              overflow_q;
    logic              unused_c;

    assign wr_hit_c   = bus.write_en && (bus.addr == DATA_ADDR);
    assign stat_hit_c = bus.write_en && (bus.addr == STAT_ADDR);
    // A write into a full queue still lands when a pop frees a slot on the same edge
    assign push_c     = wr_hit_c && (!q_full_c || pop_c);
    assign unused_c   = ^bus.data_in[wordsize-1:8];

`ifdef ASRM_UART_TX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(fifo_depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [fifo_depth];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    assign q_empty_c = (count_q == '0);
    assign q_full_c  = (count_q == CNT_W'(fifo_depth));
    assign q_head_c  = mem_q[rd_ptr_q];

    // Circular pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= bus.data_in[7:0];
    end
`else
    logic [7:0] hold_q;
    logic       valid_q;

    assign q_empty_c = !valid_q;
    assign q_full_c  = valid_q;
    assign q_head_c  = hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else if (push_c) begin
            hold_q  <= bus.data_in[7:0];
            valid_q <= 1'b1;
        end else if (pop_c) begin
            valid_q <= 1'b0;
        end
    end
`endif

    // Sticky overflow: set by a dropped write, cleared by any write to the status address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (stat_hit_c) begin
            overflow_q <= 1'b0;
        end else if (wr_hit_c && q_full_c && !pop_c) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            busy    <= (state_d != IDLE);
        end
    end

    // Next-state: tx is registered from the level the next state drives
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!q_empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = q_head_c;
                    baud_d  = BAUD_LOAD;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    bit_d   = '0;
                    baud_d  = BAUD_LOAD;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (!q_empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = q_head_c;
                        baud_d  = BAUD_LOAD;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Read-back samples pre-edge status so a same-cycle write is not yet visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data_out <= '0;
        end else if (bus.addr == STAT_ADDR) begin
            bus.data_out <= {{(wordsize-4){1'b0}}, overflow_q, q_empty_c, q_full_c, busy};
        end else begin
            bus.data_out <= '0;
        end
    end
endmodule

// File: tb/tb_asrm_uart_tx.sv
// Randomised bench for asrm_uart_tx against a frame-timing reference model (clk_div=4).
module tb_asrm_uart_tx;
    localparam int unsigned W     = 16;
    localparam int          D     = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'hFF00;
`ifdef ASRM_UART_TX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic busy;

    asrm_uart_tx_if #(.wordsize(W)) bus ();

    asrm_uart_tx #(
        .wordsize  (W),
        .base_addr (32'(BASE)),
        .clk_div   (D),
        .fifo_depth(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pending bytes, start edge of the frame on the wire, sticky overflow
    int          t;
    int          fstart;
    logic [7:0]  fbyte;
    logic [7:0]  q[$];
    logic        ovf;
    logic        m_tx;
    logic        m_busy;
    logic [15:0] m_dout;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        fstart = -1;
        fbyte  = 8'h00;
        ovf    = 1'b0;
        m_tx   = 1'b1;
        m_busy = 1'b0;
        m_dout = 16'h0000;
    endtask

    task automatic model_edge(input logic we, input logic [15:0] a, input logic [15:0] d);
        logic busy_pre, empty_pre, full_pre, pop;
        int   k;
        busy_pre  = (fstart >= 0);
        empty_pre = (q.size() == 0);
        full_pre  = (q.size() == CAP);
        m_dout = (a == BASE + 16'd1) ? {12'h000, ovf, empty_pre, full_pre, busy_pre} : 16'h0000;
        t++;
        pop = 1'b0;
        if (fstart >= 0 && (t - fstart) == 10 * D) fstart = -1;
        if (fstart < 0 && q.size() > 0) begin
            fbyte  = q.pop_front();
            fstart = t;
            pop    = 1'b1;
        end
        if (we && a == BASE) begin
            if (!full_pre || pop) q.push_back(d[7:0]);
            else ovf = 1'b1;
        end
        if (we && a == BASE + 16'd1) ovf = 1'b0;
        if (fstart >= 0) begin
            k = (t - fstart) / D;
            m_tx   = (k == 0) ? 1'b0 : (k <= 8) ? fbyte[k-1] : 1'b1;
            m_busy = 1'b1;
        end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    // One clock: drive after the falling edge, model the rising edge, check at the next fall
    task automatic cycle(input logic we, input logic [15:0] a, input logic [15:0] d);
        bus.write_en = we;
        bus.addr     = a;
        bus.data_in  = d;
        @(posedge clk);
        model_edge(we, a, d);
        @(negedge clk);
        chk("tx", 32'(tx), 32'(m_tx));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("data_out", 32'(bus.data_out), 32'(m_dout));
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return BASE;
            1:       return BASE + 16'd1;
            2:       return BASE + 16'd2;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, pick_addr(), 16'($urandom()));
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cycle(1'b1, a, d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        t     = 0;
        model_reset();
        bus.write_en = 1'b0;
        bus.addr     = 16'h0000;
        bus.data_in  = 16'h0000;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dout", 32'(bus.data_out), 32'd0);
        reset = 1'b0;

        // Status straight after reset: empty only
        cycle(1'b0, BASE + 16'd1, 16'h0000);
        chk("reset_status", 32'(bus.data_out), 32'h0004);

        // Single byte, upper data bits ignored
        wr(BASE, 16'hAB55);
        idle(45);

        // Back-to-back bytes on consecutive cycles
        wr(BASE, 16'h00A3);
        wr(BASE, 16'h000F);
        idle(90);

        // Burst of six writes while idle, then status, clear, status
        for (int i = 0; i < 6; i++) wr(BASE, 16'(8'h30 + i));
        cycle(1'b0, BASE + 16'd1, 16'h0000);
        chk("ovf_set", 32'(bus.data_out[3]), 32'd1);
        wr(BASE + 16'd1, 16'hFFFF);
        cycle(1'b0, BASE + 16'd1, 16'h0000);
        chk("ovf_clear", 32'(bus.data_out[3]), 32'(ovf));
        idle(10 * D * (CAP + 1) + 10);

        // Decode isolation: neighbouring address writes do nothing
        wr(BASE + 16'd2, 16'h0077);
        wr(16'h0000, 16'h0011);
        wr(BASE - 16'd1, 16'h0022);
        idle(20);

        // Asynchronous reset during data bit 3
        wr(BASE, 16'h00C6);
        wr(BASE, 16'h0099);
        for (int i = 0; i < 100; i++) begin
            if (fstart >= 0 && (t - fstart) == 4 * D + 1) break;
            idle(1);
        end
        chk("midframe_reached", 32'(fstart >= 0 && (t - fstart) == 4 * D + 1), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_tx", 32'(tx), 32'(m_tx));
        chk("async_busy", 32'(busy), 32'(m_busy));
        bus.write_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(50);
        wr(BASE, 16'h00FF);
        idle(45);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 7)       wr(BASE, 16'($urandom()));
            else if (r < 9)  wr(BASE + 16'd1, 16'($urandom()));
            else if (r < 11) wr(pick_addr(), 16'($urandom()));
            else             idle(1);
        end
        idle(10 * D * (CAP + 1) + 10);
        chk("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
